// File: rtl/rr_arbiter16.sv
// Round-robin arbiter: 16 requesters, rotating "highest index first" scan, grant held until done/withdraw.
// Registered outputs, one edge from req to grant. Optional forced release after MAX_HOLD cycles under ARB_TIMEOUT_EN.
module rr_arbiter16 #(
  parameter int N    = 16,
  parameter int IDXW = 4
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int MAX_HOLD = 8
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            arb_en,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid,
  output logic            timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [N-1:0]    grant_q, grant_d;
  logic            vld_q, vld_d;
  logic            new_grant;

  logic [IDXW:0]   win_idle, win_rel;
  logic [IDXW-1:0] rel_ptr;
  logic            release_n, release_f;

  // Upper copy keeps only indices <= p so they outrank the wrapped-around lower copy.
  function automatic logic [IDXW:0] pick(input logic [N-1:0] r, input logic [IDXW-1:0] p);
    logic [N-1:0]   lo_mask;
    logic [2*N-1:0] dbl;
    logic [IDXW:0]  res;
    for (int k = 0; k < N; k++) lo_mask[k] = (k <= int'(p));
    dbl = {r & lo_mask, r};
    res = '0;
    for (int k = 0; k < 2*N; k++) begin
      if (dbl[k]) res = {1'b1, IDXW'(k % N)};
    end
    return res;
  endfunction

  assign rel_ptr   = idx_q - IDXW'(1);
  assign win_idle  = pick(req, ptr_q);
  assign win_rel   = pick(req, rel_ptr);
  assign release_n = (state_q == GRANT) && (done || !req[idx_q]);

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_q, hold_d;
  logic       to_q, to_d;

  assign release_f = (state_q == GRANT) && !release_n && (hold_q == HOLD_LAST);
`else
  assign release_f = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    grant_d   = grant_q;
    vld_d     = vld_q;
    new_grant = 1'b0;
    if (state_q == IDLE) begin
      if (arb_en && win_idle[IDXW]) begin
        state_d          = GRANT;
        idx_d            = win_idle[IDXW-1:0];
        grant_d          = '0;
        grant_d[idx_d]   = 1'b1;
        vld_d            = 1'b1;
        new_grant        = 1'b1;
      end
    end else if (release_n || release_f) begin
      ptr_d = rel_ptr;
      if (arb_en && win_rel[IDXW]) begin
        idx_d          = win_rel[IDXW-1:0];
        grant_d        = '0;
        grant_d[idx_d] = 1'b1;
        new_grant      = 1'b1;
      end else begin
        state_d = IDLE;
        idx_d   = '0;
        grant_d = '0;
        vld_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '1;
      idx_q   <= '0;
      grant_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      vld_q   <= vld_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_comb begin
    to_d = release_f;
    if (new_grant || state_d == IDLE) hold_d = '0;
    else if (state_q == GRANT)        hold_d = hold_q + 8'd1;
    else                              hold_d = hold_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      to_q   <= 1'b0;
    end else begin
      hold_q <= hold_d;
      to_q   <= to_d;
    end
  end

  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = vld_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Bench for rr_arbiter16: vector table, corner sequences and a randomized run against a scan-order model.
module tb_rr_arbiter16;

  localparam int MAX_HOLD_TB = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arb_en = 1'b0;
  logic [15:0] req = '0;
  logic        done = 1'b0;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_valid;
  logic        timeout;

  int n_cmp = 0;
  int n_bad = 0;

  int m_owner;
  int m_ptr;
  int m_hold;
  bit m_to;

  typedef struct {
    bit          rst;
    bit          en;
    logic [15:0] rq;
    bit          dn;
    bit          vld;
    logic [3:0]  idx;
  } vec_t;

  vec_t tbl[25];

  always #5 clk = ~clk;

  rr_arbiter16 dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req(req), .done(done),
    .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid), .timeout(timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input bit vld, input logic [3:0] idx, input bit to);
    logic [15:0] eg;
    eg = '0;
    if (vld) eg[idx] = 1'b1;
    chk({name, ".valid"},   32'(grant_valid), 32'(vld));
    chk({name, ".idx"},     32'(grant_idx),   vld ? 32'(idx) : 32'd0);
    chk({name, ".grant"},   32'(grant),       32'(eg));
    chk({name, ".timeout"}, 32'(timeout),     32'(to));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; arb_en = 1'b0; req = '0; done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int win(input logic [15:0] r, input int p);
    int k;
    for (int i = 0; i < 16; i++) begin
      k = (p - i + 16) % 16;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_step();
    bit rel, frc;
    int w;
    m_to = 1'b0;
    if (m_owner < 0) begin
      if (arb_en && req != 16'h0) begin
        m_owner = win(req, m_ptr);
        m_hold  = 0;
      end
    end else begin
      rel = done || !req[m_owner];
      frc = 1'b0;
`ifdef ARB_TIMEOUT_EN
      frc = !rel && (m_hold == MAX_HOLD_TB - 1);
`endif
      if (rel || frc) begin
        m_ptr = (m_owner + 15) % 16;
        w = win(req, m_ptr);
        if (arb_en && w >= 0) begin
          m_owner = w;
          m_hold  = 0;
        end else begin
          m_owner = -1;
        end
        m_to = frc;
      end else begin
        m_hold++;
      end
    end
  endtask

  initial begin
    // rst, en, req, done -> valid, idx
    tbl[0]  = '{1'b0, 1'b1, 16'h0008, 1'b0, 1'b1, 4'd3};
    tbl[1]  = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 4'd0};
    tbl[2]  = '{1'b0, 1'b1, 16'h000C, 1'b0, 1'b1, 4'd2};
    tbl[3]  = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 4'd0};
    tbl[4]  = '{1'b1, 1'b1, 16'h4001, 1'b0, 1'b1, 4'd14};
    tbl[5]  = '{1'b0, 1'b1, 16'h0001, 1'b1, 1'b1, 4'd0};
    tbl[6]  = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 4'd0};
    tbl[7]  = '{1'b1, 1'b1, 16'h2080, 1'b0, 1'b1, 4'd13};
    tbl[8]  = '{1'b0, 1'b1, 16'h2080, 1'b0, 1'b1, 4'd13};
    tbl[9]  = '{1'b0, 1'b1, 16'h0080, 1'b0, 1'b1, 4'd7};
    tbl[10] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 4'd0};
    tbl[11] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 4'd0};
    tbl[12] = '{1'b0, 1'b1, 16'h0040, 1'b1, 1'b1, 4'd6};
    tbl[13] = '{1'b0, 1'b0, 16'h0040, 1'b0, 1'b1, 4'd6};
    tbl[14] = '{1'b0, 1'b0, 16'h0050, 1'b1, 1'b0, 4'd0};
    tbl[15] = '{1'b0, 1'b0, 16'h0050, 1'b0, 1'b0, 4'd0};
    tbl[16] = '{1'b0, 1'b1, 16'h0050, 1'b0, 1'b1, 4'd4};
    tbl[17] = '{1'b0, 1'b1, 16'h0050, 1'b1, 1'b1, 4'd6};
    tbl[18] = '{1'b0, 1'b1, 16'h8050, 1'b0, 1'b1, 4'd6};
    tbl[19] = '{1'b0, 1'b1, 16'h8040, 1'b0, 1'b1, 4'd6};
    tbl[20] = '{1'b0, 1'b1, 16'h8040, 1'b1, 1'b1, 4'd15};
    tbl[21] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 4'd0};
    tbl[22] = '{1'b0, 1'b1, 16'h0100, 1'b0, 1'b1, 4'd8};
    tbl[23] = '{1'b0, 1'b1, 16'h0100, 1'b1, 1'b1, 4'd8};
    tbl[24] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 4'd0};

    #3;
    chk_all("reset", 1'b0, 4'd0, 1'b0);
    do_reset();

    for (int i = 0; i < 25; i++) begin
      if (tbl[i].rst) do_reset();
      arb_en = tbl[i].en;
      req    = tbl[i].rq;
      done   = tbl[i].dn;
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].vld, tbl[i].idx, 1'b0);
    end

    // All requesting, done every cycle: strict descending rotation with wrap.
    do_reset();
    arb_en = 1'b1; req = 16'hFFFF; done = 1'b0;
    tick();
    chk_all("rot_first", 1'b1, 4'd15, 1'b0);
    done = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk_all($sformatf("rot%0d", i), 1'b1, 4'(15 - (i % 16)), 1'b0);
    end

    // Asynchronous reset while owner 12 holds the grant.
    do_reset();
    arb_en = 1'b1; req = 16'h1000; done = 1'b0;
    tick();
    chk_all("pre_rst", 1'b1, 4'd12, 1'b0);
    tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; req = 16'h1001;
    tick();
    chk_all("post_rst", 1'b1, 4'd12, 1'b0);

    // Long hold with no done.
    do_reset();
    arb_en = 1'b1; req = 16'h0021; done = 1'b0;
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < MAX_HOLD_TB; i++) begin
      tick();
      chk_all($sformatf("hold%0d", i), 1'b1, 4'd5, 1'b0);
    end
    tick();
    chk_all("forced", 1'b1, 4'd0, 1'b1);
    tick();
    chk_all("after_forced", 1'b1, 4'd0, 1'b0);
`else
    for (int i = 0; i < 120; i++) begin
      tick();
      chk_all($sformatf("hold%0d", i), 1'b1, 4'd5, 1'b0);
    end
`endif

    // Randomized traffic against the model.
    do_reset();
    m_owner = -1; m_ptr = 15; m_hold = 0; m_to = 1'b0;
    req = '0;
    for (int c = 0; c < 3000; c++) begin
      arb_en = ($urandom_range(0, 7) != 0);
      done   = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0:       req = 16'($urandom);
        1, 2, 3: req = req ^ (16'h0001 << $urandom_range(0, 15));
        4:       req = '0;
        default: ;
      endcase
      @(posedge clk);
      model_step();
      #1;
      chk_all("rand", m_owner >= 0, (m_owner >= 0) ? 4'(m_owner) : 4'd0, m_to);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter16.md
Name: rr_arbiter16

Overview:
- Sequences access to one shared resource among 16 requesters.
- Winner selection scans from a rotating pointer using the same "highest index wins" rule as our 16-to-4 priority encoder.
- The grant is held until the owner signals done or drops its request.
- Outputs are a one-hot grant, a 4-bit encoded index and a valid flag.

Parameters:
- N, 16: number of requesters; fixed at 16 in this revision.
- IDXW, 4: width of grant_idx; equals log2(N).
- MAX_HOLD, 8: maximum consecutive cycles one owner may hold the grant. Used only when ARB_TIMEOUT_EN is defined. Legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- arb_en  input  1  enables new grants; a current grant is unaffected.
- req  input  16  request lines; requester k holds req[k] high until served.
- done  input  1  owner pulses high for one cycle to release the grant.
- grant  output  16  one-hot grant; all zero when no grant.
- grant_idx  output  4  encoded index of the owner; 0 when grant_valid is low.
- grant_valid  output  1  high while a grant is held.
- timeout  output  1  one-cycle pulse on a forced release; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset: asynchronous, asserted when rst_n is low. All outputs are registered. During reset: grant=0, grant_idx=0, grant_valid=0, timeout=0, ptr=15, state=IDLE, hold counter=0.
- Winner function (combinational, from req and ptr):
  - Scan indices ptr, ptr-1, …, 0, 15, …, ptr+1 (descending, wrapping modulo 16).
  - The first set bit wins.
  - At reset (ptr=15) this is plain fixed priority: 15 highest, 0 lowest.
- State IDLE:
  - If arb_en=1 and req≠0, the next edge loads the winner and moves to GRANT.
  - Latency: req sampled at edge t gives grant_valid=1 after edge t. There is no combinational path from req to the outputs.
- State GRANT: the owner keeps the grant while req[grant_idx]=1 and done=0.
- Release condition: done=1, or req[grant_idx]=0 (request withdrawn).
  - On the release edge, ptr is set to (grant_idx-1) mod 16. grant_idx=0 wraps ptr to 15.
  - In the same edge the arbiter re-arbitrates with the new ptr over the current req. The releasing index is still a candidate but is scanned last.
  - If there is a winner and arb_en=1: stay in GRANT with the new owner. This is a back-to-back grant with no idle gap.
  - Otherwise: go to IDLE and clear grant, grant_idx and grant_valid.
- done while in IDLE is ignored.
- A sole requester that keeps req high after done is re-granted on the next cycle.
- arb_en=0 in GRANT: the current owner is unaffected. At release the arbiter goes to IDLE and does not re-grant.
- req changes on non-owner lines during GRANT have no effect until release.
- Invariants:
  - grant has at most one bit set.
  - grant == (1 << grant_idx) whenever grant_valid=1.
- Reset asserted mid-grant: outputs clear immediately (asynchronous) and ptr returns to 15.
- Implementation: a two-state FSM (IDLE, GRANT) plus the ptr register and the optional hold counter. The rotating scan is built as a double-width masked priority encode.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on every new grant and increments each cycle in GRANT.
  - When counter == MAX_HOLD-1 and no normal release occurs, the arbiter forces a release with the same ptr update and re-arbitration rules.
  - timeout=1 for exactly that one cycle after the edge. It resets to 0.
  - A normal release in the same cycle takes precedence, and timeout stays 0.
- Not defined:
  - No counter logic is built and timeout is constant 0.
  - A grant can be held indefinitely.

Test Plan:
- Reset, then req=16'h0008 with arb_en=1 → after one edge grant=16'h0008, grant_idx=3, grant_valid=1; done pulse → next cycle grant_valid=0, ptr=2.
- After reset, req=16'h4001 → grant_idx=14. done → grant_idx=0 on the next cycle with no gap. done → IDLE.
- req=16'hFFFF held, done pulsed every grant cycle → grant_idx sequence 15,14,…,1,0,15.
- Owner 13 drops req[13] mid-grant while req[7] is high → grant moves to 7 on the next cycle; done ignored in IDLE.
- rst_n pulled low while grant_idx=12 → all outputs 0 immediately. After release, req=16'h1001 → grant_idx=12 (ptr back at 15).
- ARB_TIMEOUT_EN, MAX_HOLD=8, req=16'h0021, no done → grant 5 for 8 cycles, timeout pulse, then grant 0. Without the macro, grant 5 holds for 100+ cycles.
